// File: rtl/sub_arb_pkg.sv
// Shared types and constants for the round-robin subtractor arbiter.
// Holds the datapath width, saturation limits and the output-buffer state encoding.
package sub_arb_pkg;

    localparam int DATA_W  = 8;
    localparam int MAX_REQ = 8;
    localparam int ID_W_MAX = $clog2(MAX_REQ);

    typedef logic [ID_W_MAX-1:0] id_t;

    localparam logic [DATA_W-1:0] SAT_MAX = 8'h7F;
    localparam logic [DATA_W-1:0] SAT_MIN = 8'h80;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] i_v);
        return (i_v == 8'hFF) ? i_v : i_v + 8'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority selector: first asserted request at or after i_ptr,
// ascending with wrap, returned as a one-hot grant plus its index.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    always_comb begin
        int w_c;
        w_c     = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        // Walk from lowest to highest priority so the closest request to ptr wins last
        for (int off = N - 1; off >= 0; off--) begin
            w_c = int'(i_ptr) + off;
            if (w_c >= N) begin
                w_c = w_c - N;
            end
            if (i_req[w_c]) begin
                o_grant      = '0;
                o_grant[w_c] = 1'b1;
                o_idx        = IDW'(w_c);
                o_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sub_8bit_signed.sv
// Combinational 8-bit signed subtractor A-B with overflow detection
// and optional clamping to the signed range on overflow.
module sub_8bit_signed
    import sub_arb_pkg::*;
#(
    parameter int SATURATE = 0
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_ovf
);

    logic [DATA_W-1:0] w_raw;

    assign w_raw = i_a - i_b;
    // Overflow only possible when operand signs differ and the result sign leaves A's sign
    assign o_ovf = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_raw[DATA_W-1] != i_a[DATA_W-1]);

    always_comb begin
        o_result = w_raw;
        if ((SATURATE != 0) && o_ovf) begin
            o_result = i_a[DATA_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/sub8_rr_arbiter.sv
// Round-robin arbiter sharing one signed 8-bit subtractor among NUM_REQ requesters,
// with a single-entry tagged result buffer and a saturating overflow counter.
module sub8_rr_arbiter
    import sub_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int SATURATE = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_result,
    output logic                        rsp_ovf,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [7:0]                  ovf_count
);

    localparam int ID_W = $clog2(NUM_REQ);

    buf_state_t          r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [DATA_W-1:0]   r_result;
    logic                r_ovf;
    logic [ID_W-1:0]     r_id;
    logic [7:0]          r_ovf_count;

    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_idx;
    logic                w_any;
    logic                w_can_accept;
    logic                w_accept;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [DATA_W-1:0]   w_result;
    logic                w_ovf;
    logic [DATA_W-1:0]   w_a_arr [NUM_REQ];
    logic [DATA_W-1:0]   w_b_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
            assign w_b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_rr_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_a = w_a_arr[w_idx];
    assign w_b = w_b_arr[w_idx];

    sub_8bit_signed #(
        .SATURATE (SATURATE)
    ) u_sub (
        .i_a      (w_a),
        .i_b      (w_b),
        .o_result (w_result),
        .o_ovf    (w_ovf)
    );

    assign w_can_accept = (r_state == BUF_EMPTY) || rsp_ready;
    // Gate with rst_n so no requester sees a grant while reset is held
    assign req_ready    = (rst_n && w_can_accept && w_any) ? w_grant : '0;
    assign w_accept     = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= BUF_EMPTY;
            r_ptr       <= '0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_id        <= '0;
            r_ovf_count <= '0;
        end else begin
            if (w_accept) begin
                r_state  <= BUF_FULL;
                r_result <= w_result;
                r_ovf    <= w_ovf;
                r_id     <= w_idx;
                r_ptr    <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
                if (w_ovf) begin
                    r_ovf_count <= sat_inc8(r_ovf_count);
                end
            end else if ((r_state == BUF_FULL) && rsp_ready) begin
                r_state <= BUF_EMPTY;
            end
        end
    end

    assign rsp_valid  = (r_state == BUF_FULL);
    assign rsp_result = r_result;
    assign rsp_ovf    = r_ovf;
    assign rsp_id     = r_id;
    assign ovf_count  = r_ovf_count;

endmodule

// File: tb/tb_sub8_rr_arbiter.sv
// Directed bench for sub8_rr_arbiter: a wrapping and a saturating instance share
// the same stimulus; expected values are hand-computed constants.
module tb_sub8_rr_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_a;
    logic [N*8-1:0] req_b;
    logic           rsp_ready;

    logic [N-1:0]   req_ready0, req_ready1;
    logic           rsp_valid0, rsp_valid1;
    logic [7:0]     rsp_result0, rsp_result1;
    logic           rsp_ovf0, rsp_ovf1;
    logic [1:0]     rsp_id0, rsp_id1;
    logic [7:0]     ovf_count0, ovf_count1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sub8_rr_arbiter #(.NUM_REQ(N), .SATURATE(0)) dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready0),
        .rsp_valid  (rsp_valid0),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result0),
        .rsp_ovf    (rsp_ovf0),
        .rsp_id     (rsp_id0),
        .ovf_count  (ovf_count0)
    );

    sub8_rr_arbiter #(.NUM_REQ(N), .SATURATE(1)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready1),
        .rsp_valid  (rsp_valid1),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result1),
        .rsp_ovf    (rsp_ovf1),
        .rsp_id     (rsp_id1),
        .ovf_count  (ovf_count1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        logic [7:0] va, vb;
        va = a[7:0];
        vb = b[7:0];
        req_a[8*i +: 8] = va;
        req_b[8*i +: 8] = vb;
    endtask

    task automatic do_op(input int i, input int a, input int b);
        req_valid = '0;
        set_op(i, a, b);
        req_valid[i] = 1'b1;
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        $display("op req%0d a=%0d b=%0d -> wrap=%0d sat=%0d ovf=%0d", i, a, b,
                 $signed(rsp_result0), $signed(rsp_result1), rsp_ovf0);
    endtask

    function automatic int s8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    initial begin
        int exp_ids[9];
        exp_ids = '{0, 1, 2, 3, 0, 1, 2, 0, 2};
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset held: outputs 0, no grant even with a valid request
        req_valid = 4'b0001;
        #12;
        chk("rst0_valid", int'(rsp_valid0), 0);
        chk("rst0_ready", int'(req_ready0), 0);
        chk("rst0_cnt", int'(ovf_count0), 0);

        // Load buffer and count 3 overflows
        @(negedge clk);
        rst_n = 1'b1;
        set_op(0, 127, -1);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        repeat (3) tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        chk("pre_valid", int'(rsp_valid0), 1);
        chk("pre_cnt", int'(ovf_count0), 3);
        chk("pre_result", s8(rsp_result0), -128);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("amid_valid", int'(rsp_valid0), 0);
        chk("amid_result", int'(rsp_result0), 0);
        chk("amid_ovf", int'(rsp_ovf0), 0);
        chk("amid_id", int'(rsp_id0), 0);
        chk("amid_cnt", int'(ovf_count0), 0);
        chk("amid_ready", int'(req_ready0), 0);

        @(negedge clk);
        rst_n = 1'b1;
        set_op(0, 5, 3);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        chk("post_valid", int'(rsp_valid0), 1);
        chk("post_result", s8(rsp_result0), 2);
        chk("post_ovf", int'(rsp_ovf0), 0);
        chk("post_id", int'(rsp_id0), 0);
        tick();
        chk("drain_valid", int'(rsp_valid0), 0);

        // Overflow cases, wrap vs saturate
        do_op(0, 127, -1);
        chk("o1_wrap", s8(rsp_result0), -128);
        chk("o1_sat", s8(rsp_result1), 127);
        chk("o1_ovf", int'(rsp_ovf0), 1);
        chk("o1_ovf_sat", int'(rsp_ovf1), 1);
        do_op(0, -128, 1);
        chk("o2_wrap", s8(rsp_result0), 127);
        chk("o2_sat", s8(rsp_result1), -128);
        chk("o2_ovf", int'(rsp_ovf0), 1);
        do_op(0, -1, 127);
        chk("o3_wrap", s8(rsp_result0), -128);
        chk("o3_sat", s8(rsp_result1), -128);
        chk("o3_ovf", int'(rsp_ovf0), 0);
        chk("o3_cnt", int'(ovf_count0), 2);
        do_op(0, 64, -64);
        chk("o4_wrap", s8(rsp_result0), -128);
        chk("o4_sat", s8(rsp_result1), 127);
        chk("o4_ovf", int'(rsp_ovf1), 1);
        chk("o4_cnt", int'(ovf_count1), 3);

        // Fresh reset so the pointer starts at 0 for fairness
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 10 * i + 1, 1);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (k == 5) req_valid = 4'b0101;
            $display("grant id=%0d result=%0d", rsp_id0, s8(rsp_result0));
            chk($sformatf("rr%0d_id", k), int'(rsp_id0), exp_ids[k]);
            chk($sformatf("rr%0d_res", k), s8(rsp_result0), 10 * exp_ids[k]);
        end
        chk("rr_cnt", int'(ovf_count0), 0);

        // Backpressure with req1 waiting
        rsp_ready = 1'b0;
        set_op(1, 10, 3);
        req_valid = 4'b0010;
        #1;
        chk("bp_ready0", int'(req_ready0), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp%0d_ready", k), int'(req_ready0), 0);
            chk($sformatf("bp%0d_id", k), int'(rsp_id0), 2);
            chk($sformatf("bp%0d_res", k), s8(rsp_result0), 20);
            chk($sformatf("bp%0d_valid", k), int'(rsp_valid0), 1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", int'(req_ready0), 2);
        tick();
        req_valid = '0;
        $display("bp accept id=%0d result=%0d", rsp_id0, s8(rsp_result0));
        chk("bp_new_valid", int'(rsp_valid0), 1);
        chk("bp_new_id", int'(rsp_id0), 1);
        chk("bp_new_res", s8(rsp_result0), 7);
        tick();
        chk("bp_empty", int'(rsp_valid0), 0);

        // Saturating overflow counter
        set_op(3, -128, 1);
        req_valid = 4'b1000;
        repeat (254) tick();
        chk("cnt_254", int'(ovf_count0), 254);
        tick();
        chk("cnt_255", int'(ovf_count0), 255);
        repeat (45) tick();
        $display("300 overflow ops -> count=%0d", ovf_count0);
        chk("cnt_hold", int'(ovf_count0), 255);
        chk("cnt_hold_sat", int'(ovf_count1), 255);
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
